// File: rtl/key_time_entry_if.sv
// Keypad-to-clock-core bus for the time-entry block: key events in,
// committed time, edit buffer and status strobes out.
interface key_time_entry_if;
  logic        Key_flag;
  logic [3:0]  Key_Value;
  logic [23:0] Set_Time;
  logic        Set_Valid;
  logic        Edit_Active;
  logic [23:0] Edit_Time;
  logic [2:0]  Digit_Idx;
  logic        Err;
  logic        Timeout;

  // Keypad/consumer side
  modport master (
    output Key_flag, Key_Value,
    input  Set_Time, Set_Valid, Edit_Active, Edit_Time, Digit_Idx, Err, Timeout
  );

  // Time-entry block side
  modport slave (
    input  Key_flag, Key_Value,
    output Set_Time, Set_Valid, Edit_Active, Edit_Time, Digit_Idx, Err, Timeout
  );
endinterface

// File: rtl/key_time_entry.sv
// Keypad-driven HH:MM:SS edit session: collects six range-checked BCD digits,
// supports backspace/cancel/restart/timeout and strobes the committed time out.
module key_time_entry #(
  parameter int TIMEOUT_CYC = 500_000_000
) (
  input logic             Clk,
  input logic             Rst,
  key_time_entry_if.slave kte
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  localparam logic [3:0] KEY_A = 4'd10;
  localparam logic [3:0] KEY_B = 4'd11;
  localparam logic [3:0] KEY_C = 4'd12;
  localparam logic [3:0] KEY_F = 4'd15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENTRY  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t           state_reg;
  logic [23:0]      buf_reg;
  logic [2:0]       idx_reg;
  logic [23:0]      set_time_reg;
  logic             set_valid_reg;
  logic             edit_active_reg;
  logic             err_reg;
  logic             timeout_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic [3:0]  digit_max [8];
  logic [23:0] buf_write;
  logic [23:0] buf_back;
  logic        digit_ok;

  // Highest legal digit per position; Hu depends on the buffered Ht.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_max
      if (gi == 0) begin : g_ht
        assign digit_max[gi] = 4'd2;
      end else if (gi == 1) begin : g_hu
        assign digit_max[gi] = (buf_reg[23:20] == 4'd2) ? 4'd3 : 4'd9;
      end else if (gi == 2 || gi == 4) begin : g_tens
        assign digit_max[gi] = 4'd5;
      end else if (gi == 3 || gi == 5) begin : g_units
        assign digit_max[gi] = 4'd9;
      end else begin : g_none
        assign digit_max[gi] = 4'd0;
      end
    end
  endgenerate

  always_comb begin
    buf_write = buf_reg;
    buf_back  = buf_reg;
    for (int i = 0; i < 6; i++) begin
      if (idx_reg == 3'(i))
        buf_write[(5-i)*4 +: 4] = kte.Key_Value;
      if (idx_reg == 3'(i + 1))
        buf_back[(5-i)*4 +: 4] = 4'd0;
    end
    digit_ok = (idx_reg < 3'd6) && (kte.Key_Value <= digit_max[idx_reg]);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_reg       <= IDLE;
      buf_reg         <= '0;
      idx_reg         <= '0;
      set_time_reg    <= '0;
      set_valid_reg   <= 1'b0;
      edit_active_reg <= 1'b0;
      err_reg         <= 1'b0;
      timeout_reg     <= 1'b0;
      cnt_reg         <= '0;
    end else begin
      set_valid_reg <= 1'b0;
      err_reg       <= 1'b0;
      timeout_reg   <= 1'b0;
      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          if (kte.Key_flag && kte.Key_Value == KEY_A) begin
            buf_reg         <= '0;
            idx_reg         <= '0;
            state_reg       <= ENTRY;
            edit_active_reg <= 1'b1;
          end
        end
        ENTRY: begin
          // A key in the expiry cycle takes priority over the timeout.
          if (kte.Key_flag) begin
            cnt_reg <= '0;
            if (kte.Key_Value <= 4'd9) begin
              if (digit_ok) begin
                buf_reg <= buf_write;
                idx_reg <= idx_reg + 3'd1;
              end else begin
                err_reg <= 1'b1;
              end
            end else begin
              case (kte.Key_Value)
                KEY_A: begin
                  buf_reg <= '0;
                  idx_reg <= '0;
                end
                KEY_B: begin
                  if (idx_reg != 3'd0) begin
                    buf_reg <= buf_back;
                    idx_reg <= idx_reg - 3'd1;
                  end else begin
                    err_reg <= 1'b1;
                  end
                end
                KEY_C: begin
                  state_reg       <= IDLE;
                  edit_active_reg <= 1'b0;
                end
                KEY_F: begin
                  if (idx_reg == 3'd6) begin
                    state_reg       <= COMMIT;
                    edit_active_reg <= 1'b0;
                  end else begin
                    err_reg <= 1'b1;
                  end
                end
                default: ;
              endcase
            end
          end else if (cnt_reg == CNT_LAST) begin
            timeout_reg     <= 1'b1;
            state_reg       <= IDLE;
            edit_active_reg <= 1'b0;
            cnt_reg         <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        COMMIT: begin
          set_time_reg  <= buf_reg;
          set_valid_reg <= 1'b1;
          state_reg     <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign kte.Set_Time    = set_time_reg;
  assign kte.Set_Valid   = set_valid_reg;
  assign kte.Edit_Active = edit_active_reg;
  assign kte.Edit_Time   = buf_reg;
  assign kte.Digit_Idx   = idx_reg;
  assign kte.Err         = err_reg;
  assign kte.Timeout     = timeout_reg;

endmodule

// File: tb/tb_key_time_entry.sv
// Directed bench for key_time_entry with a 16-cycle timeout.
module tb_key_time_entry;

  logic Clk;
  logic Rst;
  int   checks;
  int   errors;

  key_time_entry_if kte ();

  key_time_entry #(.TIMEOUT_CYC(16)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .kte (kte.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Called at a negedge; key sampled at the next posedge, returns at the following negedge.
  task automatic press(input logic [3:0] k);
    kte.Key_flag  = 1'b1;
    kte.Key_Value = k;
    @(negedge Clk);
    kte.Key_flag  = 1'b0;
    kte.Key_Value = 4'd0;
  endtask

  task automatic press_seq(input logic [3:0] keys [], input int n);
    for (int i = 0; i < n; i++) press(keys[i]);
  endtask

  task automatic test_reset;
    Rst = 1'b1;
    kte.Key_flag = 1'b0;
    kte.Key_Value = 4'd0;
    repeat (2) @(negedge Clk);
    checks++; if (kte.Set_Time !== 24'h0) begin errors++; $display("FAIL reset_set_time got %h exp %h", kte.Set_Time, 24'h0); end
    checks++; if (kte.Edit_Time !== 24'h0) begin errors++; $display("FAIL reset_edit_time got %h exp %h", kte.Edit_Time, 24'h0); end
    checks++; if (kte.Digit_Idx !== 3'd0) begin errors++; $display("FAIL reset_idx got %0d exp 0", kte.Digit_Idx); end
    checks++; if ({kte.Set_Valid, kte.Edit_Active, kte.Err, kte.Timeout} !== 4'b0000) begin errors++;
      $display("FAIL reset_strobes got %b exp 0000", {kte.Set_Valid, kte.Edit_Active, kte.Err, kte.Timeout}); end
    Rst = 1'b0;
    @(negedge Clk);
    $display("reset released");
  endtask

  task automatic test_basic_commit;
    logic [3:0] k [] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
    press(4'd10);
    checks++; if (kte.Edit_Active !== 1'b1) begin errors++; $display("FAIL basic_active_after_A got %b exp 1", kte.Edit_Active); end
    press_seq(k, 6);
    checks++; if (kte.Edit_Time !== 24'h123456) begin errors++; $display("FAIL basic_edit_time got %h exp 123456", kte.Edit_Time); end
    checks++; if (kte.Digit_Idx !== 3'd6) begin errors++; $display("FAIL basic_idx got %0d exp 6", kte.Digit_Idx); end
    checks++; if (kte.Edit_Active !== 1'b1) begin errors++; $display("FAIL basic_active_before_F got %b exp 1", kte.Edit_Active); end
    press(4'd15);
    checks++; if ({kte.Set_Valid, kte.Edit_Active} !== 2'b00) begin errors++;
      $display("FAIL basic_commit_cycle got valid,active=%b exp 00", {kte.Set_Valid, kte.Edit_Active}); end
    @(negedge Clk);
    checks++; if (kte.Set_Valid !== 1'b1) begin errors++; $display("FAIL basic_set_valid got %b exp 1", kte.Set_Valid); end
    checks++; if (kte.Set_Time !== 24'h123456) begin errors++; $display("FAIL basic_set_time got %h exp 123456", kte.Set_Time); end
    @(negedge Clk);
    checks++; if (kte.Set_Valid !== 1'b0) begin errors++; $display("FAIL basic_set_valid_width got %b exp 0", kte.Set_Valid); end
    $display("basic commit: Set_Time=%h", kte.Set_Time);
  endtask

  task automatic test_range;
    logic [3:0] k [] = '{4'd3, 4'd5, 4'd9, 4'd5, 4'd9};
    press(4'd10);
    press(4'd2);
    press(4'd4);
    checks++; if (kte.Err !== 1'b1) begin errors++; $display("FAIL range_hu_err got %b exp 1", kte.Err); end
    checks++; if (kte.Digit_Idx !== 3'd1) begin errors++; $display("FAIL range_hu_idx got %0d exp 1", kte.Digit_Idx); end
    press_seq(k, 5);
    checks++; if (kte.Err !== 1'b0) begin errors++; $display("FAIL range_err_cleared got %b exp 0", kte.Err); end
    press(4'd15);
    @(negedge Clk);
    checks++; if (kte.Set_Time !== 24'h235959) begin errors++; $display("FAIL range_set_time got %h exp 235959", kte.Set_Time); end
    $display("range: Set_Time=%h", kte.Set_Time);
  endtask

  task automatic test_backspace;
    logic [3:0] z [] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    press(4'd10);
    press(4'd1);
    press(4'd2);
    press(4'd11);
    checks++; if (kte.Edit_Time !== 24'h100000) begin errors++; $display("FAIL bksp_first got %h exp 100000", kte.Edit_Time); end
    press(4'd11);
    checks++; if ({kte.Edit_Time, kte.Digit_Idx, kte.Err} !== {24'h0, 3'd0, 1'b0}) begin errors++;
      $display("FAIL bksp_second got time=%h idx=%0d err=%b exp 000000/0/0", kte.Edit_Time, kte.Digit_Idx, kte.Err); end
    press(4'd11);
    checks++; if ({kte.Digit_Idx, kte.Err} !== {3'd0, 1'b1}) begin errors++;
      $display("FAIL bksp_third got idx=%0d err=%b exp 0/1", kte.Digit_Idx, kte.Err); end
    press(4'd10);
    press_seq(z, 6);
    press(4'd7);
    checks++; if ({kte.Digit_Idx, kte.Err} !== {3'd6, 1'b1}) begin errors++;
      $display("FAIL full_extra_digit got idx=%0d err=%b exp 6/1", kte.Digit_Idx, kte.Err); end
    $display("backspace: idx=%0d", kte.Digit_Idx);
  endtask

  task automatic test_cancel;
    logic [3:0] k [] = '{4'd10, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd15};
    int valid_seen;
    press_seq(k, 8);
    @(negedge Clk);
    press(4'd10);
    press(4'd0);
    press(4'd9);
    press(4'd12);
    checks++; if (kte.Edit_Active !== 1'b0) begin errors++; $display("FAIL cancel_active got %b exp 0", kte.Edit_Active); end
    checks++; if (kte.Set_Time !== 24'h123456) begin errors++; $display("FAIL cancel_set_time got %h exp 123456", kte.Set_Time); end
    checks++; if ({kte.Edit_Time, kte.Digit_Idx} !== {24'h090000, 3'd2}) begin errors++;
      $display("FAIL cancel_retained got %h/%0d exp 090000/2", kte.Edit_Time, kte.Digit_Idx); end
    press(4'd10);
    press(4'd1);
    press(4'd15);
    checks++; if (kte.Err !== 1'b1) begin errors++; $display("FAIL early_F_err got %b exp 1", kte.Err); end
    valid_seen = 0;
    repeat (3) begin
      @(negedge Clk);
      if (kte.Set_Valid) valid_seen++;
    end
    checks++; if (valid_seen !== 0) begin errors++; $display("FAIL early_F_valid got %0d pulses exp 0", valid_seen); end
    press(4'd12);
    $display("cancel: Set_Time=%h", kte.Set_Time);
  endtask

  task automatic test_timeout;
    int early;
    early = 0;
    press(4'd10);
    for (int i = 1; i <= 15; i++) begin
      @(negedge Clk);
      if (kte.Timeout) early++;
    end
    checks++; if (early !== 0) begin errors++; $display("FAIL timeout_early got %0d pulses exp 0", early); end
    @(negedge Clk);
    checks++; if ({kte.Timeout, kte.Edit_Active} !== 2'b10) begin errors++;
      $display("FAIL timeout_fire got timeout,active=%b exp 10", {kte.Timeout, kte.Edit_Active}); end
    @(negedge Clk);
    checks++; if (kte.Timeout !== 1'b0) begin errors++; $display("FAIL timeout_width got %b exp 0", kte.Timeout); end
    press(4'd10);
    repeat (15) @(negedge Clk);
    press(4'd1);
    checks++; if ({kte.Timeout, kte.Edit_Active, kte.Digit_Idx} !== {1'b0, 1'b1, 3'd1}) begin errors++;
      $display("FAIL timeout_key_wins got to=%b act=%b idx=%0d exp 0/1/1", kte.Timeout, kte.Edit_Active, kte.Digit_Idx); end
    press(4'd12);
    $display("timeout done");
  endtask

  task automatic test_reset_mid;
    int bad;
    press(4'd10);
    press(4'd1);
    press(4'd2);
    press(4'd3);
    #1 Rst = 1'b1;
    #1;
    checks++; if ({kte.Edit_Time, kte.Digit_Idx, kte.Edit_Active, kte.Set_Time} !== {24'h0, 3'd0, 1'b0, 24'h0}) begin errors++;
      $display("FAIL midreset_async got edit=%h idx=%0d act=%b set=%h exp all 0",
               kte.Edit_Time, kte.Digit_Idx, kte.Edit_Active, kte.Set_Time); end
    @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    press(4'd15);
    bad = 0;
    if (kte.Err || kte.Set_Valid) bad++;
    @(negedge Clk);
    if (kte.Err || kte.Set_Valid) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL midreset_F_idle got %0d strobes exp 0", bad); end
    $display("mid-session reset done");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic_commit();
    test_range();
    test_backspace();
    test_cancel();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
